// File: rtl/reader_pkg.sv
// reader_pkg: shared definitions for the reader frame controller.
//   state_t       : 2-bit FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default data bits per frame
package reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/reader_shift.sv
// reader_shift: serial-in/parallel-out shift chain, MSB first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears data)
//   en         : shift si into the LSB this cycle
//   clr        : synchronous clear of the whole chain; has priority over en
//   si         : serial data bit
//   data       : current chain contents
module reader_shift #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             si,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clr) begin
      data <= '0;
    end else if (en) begin
      data <= {data[WIDTH-2:0], si};
    end
  end

endmodule

// File: rtl/reader_ctrl.sv
// reader_ctrl: frame controller for the reader shift chain.
// Counts exactly WIDTH strobed bits per frame, then freezes the word and
// offers it on a valid/ready port.
// Optional build macro READER_CTRL_PARITY_EN: each frame carries one extra
// even-parity bit after the data bits; parity_err reports a mismatch.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a frame (accepted in IDLE, or in DONE with dout_ready)
//   abort       : drop the frame in progress (SHIFT only)
//   si/si_valid : serial bit and its strobe, MSB first
//   busy        : FSM is in SHIFT
//   bit_cnt     : bits captured in the current frame (parity bit included)
//   dout        : assembled word
//   dout_valid  : word available, held until dout_ready
//   dout_ready  : consumer accepts the word on dout_valid & dout_ready
//   overrun     : sticky, a bit was strobed outside SHIFT; cleared by start
//   parity_err  : parity result of the last frame (0 without the macro)
// Handshake: a word transfers on any cycle where dout_valid and dout_ready
// are both high; dout_valid never drops without that transfer (or reset),
// and dout does not change while dout_valid is high.
// The internal signal `state` is the FSM state for debug observation.
module reader_ctrl
  import reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             si,
  input  logic             si_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef READER_CTRL_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  // With parity, CNT_W must also hold WIDTH+1.
  localparam int FRAME_BITS = WIDTH + PARITY_BITS;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             overrun_q;
  logic             strobe;     // a bit is consumed by the frame this cycle
  logic             last_bit;   // the next consumed bit completes the frame
  logic             shift_en;
  logic             shift_clr;  // a start has been accepted
  logic [WIDTH-1:0] data;

  assign strobe   = (state == ST_SHIFT) && si_valid && !abort;
  assign last_bit = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

`ifdef READER_CTRL_PARITY_EN
  // The parity bit is counted but never enters the data chain.
  assign shift_en = strobe && (bit_cnt_q < CNT_W'(WIDTH));
`else
  assign shift_en = strobe;
`endif

  always_comb begin
    state_n   = state;
    shift_clr = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_SHIFT;
          shift_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        // abort wins over a bit strobed in the same cycle; start is ignored
        if (abort) begin
          state_n = ST_IDLE;
        end else if (si_valid && last_bit) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (dout_ready) begin
          if (start) begin
            state_n   = ST_SHIFT;
            shift_clr = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_n;
      if (shift_clr) begin
        bit_cnt_q <= '0;
      end else if (strobe) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (shift_clr) begin
        overrun_q <= 1'b0;
      end else if (si_valid && (state != ST_SHIFT)) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef READER_CTRL_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (shift_clr) begin
      parity_q <= 1'b0;
    end else if (strobe && last_bit) begin
      parity_q <= ^data ^ si;
    end
  end
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  reader_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .clr   (shift_clr),
    .si    (si),
    .data  (data)
  );

  assign busy       = (state == ST_SHIFT);
  assign dout_valid = (state == ST_DONE);
  assign bit_cnt    = bit_cnt_q;
  assign dout       = data;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_reader_ctrl.sv
module tb_reader_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef READER_CTRL_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          si;
  logic          si_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;
  logic          parity_err;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  reader_ctrl #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .si         (si),
    .si_valid   (si_valid),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // one clock edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    si       = b;
    si_valid = 1'b1;
    tick();
    si_valid = 1'b0;
    si       = 1'b0;
  endtask

  // MSB first; gap>0 inserts (i % gap) idle cycles after bit i
  task automatic send_word(input logic [W-1:0] w, input int gap, input logic par_flip);
    logic [W-1:0] wv;
    wv = w;
    exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(wv[i]);
      if (gap > 0) begin
        for (int g = 0; g < (i % gap); g++) tick();
      end
    end
`ifdef READER_CTRL_PARITY_EN
    send_bit((^wv) ^ par_flip);
`else
    if (par_flip) $display("[TB] parity flip ignored in this build");
`endif
  endtask

  // scoreboard: compare the held word with the oldest expected one
  task automatic check_word(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty expected queue", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_dout"}, dout, e);
      check({tag, "_valid"}, dout_valid, 1'b1);
      check({tag, "_cnt"}, bit_cnt, FRAME);
      check({tag, "_busy"}, busy, 1'b0);
    end
  endtask

  task automatic accept();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    si = 1'b0; si_valid = 1'b0; dout_ready = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", bit_cnt, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity", parity_err, 1'b0);
    #10 rst_n = 1'b1;
    tick();

    // 1: 0xA5 with a strobe every cycle
    do_start();
    check("t1_busy", busy, 1'b1);
    check("t1_cnt0", bit_cnt, 0);
    for (int i = W - 1; i >= 1; i--) send_bit(8'hA5 >> i);
    check("t1_valid_early", dout_valid, 1'b0);
    check("t1_cnt7", bit_cnt, 7);
    exp_q.push_back(8'hA5);
    send_bit(1'b1);
`ifdef READER_CTRL_PARITY_EN
    check("t1_valid_pre_parity", dout_valid, 1'b0);
    send_bit(1'b0);
`endif
    check_word("t1");
    check("t1_parity", parity_err, 1'b0);
    accept();
    check("t1_idle_valid", dout_valid, 1'b0);
    check("t1_idle_busy", busy, 1'b0);
    check("t1_idle_dout", dout, 8'hA5);

    // 2: same word with gapped strobes
    do_start();
    send_word(8'hA5, 3, 1'b0);
    check_word("t2");

    // 3: consumer stalls 5 cycles while 2 stray bits arrive
    for (int c = 0; c < 5; c++) begin
      si       = (c == 1);
      si_valid = (c == 1) || (c == 3);
      tick();
    end
    si = 1'b0; si_valid = 1'b0;
    check("t3_dout", dout, 8'hA5);
    check("t3_valid", dout_valid, 1'b1);
    check("t3_overrun", overrun, 1'b1);
    accept();
    check("t3_overrun_idle", overrun, 1'b1);
    do_start();
    check("t3_overrun_clr", overrun, 1'b0);

    // 4: abort after 4 bits (abort collides with a strobe), then 0x3C
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("t4_cnt4", bit_cnt, 4);
    abort = 1'b1; si = 1'b1; si_valid = 1'b1;
    tick();
    abort = 1'b0; si = 1'b0; si_valid = 1'b0;
    check("t4_abort_busy", busy, 1'b0);
    check("t4_abort_valid", dout_valid, 1'b0);
    check("t4_abort_overrun", overrun, 1'b0);
    do_start();
    check("t4_restart_cnt", bit_cnt, 0);
    for (int i = 7; i >= 4; i--) send_bit(8'h3C >> i);
    // start while shifting must be ignored
    do_start();
    check("t4_start_ignored", bit_cnt, 4);
    check("t4_partial", dout, 8'h03);
    exp_q.push_back(8'h3C);
    for (int i = 3; i >= 0; i--) send_bit(8'h3C >> i);
`ifdef READER_CTRL_PARITY_EN
    send_bit(1'b0);
`endif
    check_word("t4");

    // 5: accept and start together, then 0xFF back to back
    dout_ready = 1'b1; start = 1'b1;
    tick();
    dout_ready = 1'b0; start = 1'b0;
    check("t5_busy", busy, 1'b1);
    check("t5_valid", dout_valid, 1'b0);
    check("t5_cnt", bit_cnt, 0);
    send_word(8'hFF, 0, 1'b0);
    check_word("t5");
    // abort in DONE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_done_valid", dout_valid, 1'b1);
    check("t5_abort_done_dout", dout, 8'hFF);
    accept();

    // 6: strobe in IDLE sets overrun
    send_bit(1'b1);
    check("t6_idle_overrun", overrun, 1'b1);
    check("t6_idle_cnt", bit_cnt, FRAME);
    check("t6_idle_dout", dout, 8'hFF);

`ifdef READER_CTRL_PARITY_EN
    // 7: parity good then bad
    do_start();
    send_word(8'h01, 0, 1'b0);
    check_word("t7_good");
    check("t7_good_perr", parity_err, 1'b0);
    accept();
    do_start();
    send_word(8'h01, 0, 1'b1);
    check_word("t7_bad");
    check("t7_bad_perr", parity_err, 1'b1);
    accept();
    check("t7_perr_hold", parity_err, 1'b1);
    do_start();
    check("t7_perr_clr", parity_err, 1'b0);
`else
    do_start();
    check("t7_parity_const", parity_err, 1'b0);
`endif

    // 8: reset mid-frame clears everything asynchronously
    if (!busy) do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    si_valid = 1'b1;  // leave a strobe pending while in reset
    #3 rst_n = 1'b0;
    #1;
    check("t8_busy", busy, 1'b0);
    check("t8_cnt", bit_cnt, 0);
    check("t8_dout", dout, 0);
    check("t8_valid", dout_valid, 1'b0);
    check("t8_overrun", overrun, 1'b0);
    check("t8_parity", parity_err, 1'b0);
    si_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("t8_post_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reader_ctrl.md
Name: reader_ctrl

Overview:
- Frame controller for the serial-in/parallel-out reader shift chain.
- Accepts a bit-strobed serial stream, gates shifting, and counts exactly WIDTH bits per frame.
- Freezes the assembled word and presents it on a valid/ready parallel port.
- Sits between a serial link front-end (bit strobe) and the word-consuming logic; it is the one place that decides when the shifter may shift.

Parameters:
- WIDTH, 32, data bits per frame; equals the shift chain width; legal 2..64.
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a frame.
- abort  input  1  discard the frame in progress.
- si  input  1  serial data bit, MSB of frame first.
- si_valid  input  1  qualifies si this cycle.
- busy  output  1  high in SHIFT state.
- bit_cnt  output  CNT_W  bits captured so far in the current frame.
- dout  output  WIDTH  assembled word; stable while dout_valid.
- dout_valid  output  1  word available.
- dout_ready  input  1  consumer accepts word when valid&ready.
- overrun  output  1  sticky: a bit was strobed while not in SHIFT.
- parity_err  output  1  see Optional Feature.

Behaviour:
- Reset (rst_n low, async): state IDLE; busy=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0, parity_err=0.
- States: IDLE, SHIFT, DONE; encoded as a 2-bit register.
- IDLE, start=1 -> SHIFT; bit_cnt=0; overrun cleared; shift register cleared.
- IDLE, si_valid=1 -> bit ignored; overrun set.
- SHIFT, si_valid=1 -> data <= {data[WIDTH-2:0], si}; bit_cnt+1.
- SHIFT, si_valid=0 -> hold; no timeout.
- SHIFT, si_valid on the bit that makes bit_cnt reach WIDTH -> DONE on the same edge.
  - dout_valid high from that edge; latency 0 cycles after the last bit edge.
  - bit_cnt reads WIDTH in DONE.
- SHIFT, abort=1 -> IDLE; word discarded; abort wins over a simultaneous si_valid.
- SHIFT, start=1 -> ignored.
- DONE: dout and dout_valid held until dout_ready=1.
  - si_valid in DONE sets overrun; the bit is dropped and dout is unchanged.
  - dout_valid&dout_ready with start=0 -> IDLE; dout_valid=0 next cycle.
  - dout_valid&dout_ready with start=1 -> SHIFT directly (back-to-back frames); bit_cnt=0.
  - abort in DONE has no effect; the word is already committed.
- dout is driven from the internal shift register; it changes only in SHIFT.
- Reset asserted mid-frame: partial word lost, outputs return to reset values immediately.

Optional Feature:
- Macro: READER_CTRL_PARITY_EN.
- With macro: the frame is WIDTH data bits plus one even-parity bit.
  - After the WIDTH-th bit the FSM remains in SHIFT for one more strobed bit.
  - On that bit: parity_err <= ^data ^ si; transition to DONE.
  - bit_cnt reaches WIDTH+1 in DONE.
  - parity_err is valid while dout_valid and cleared on the next start.
- Without macro: no parity bit is expected; parity_err is constant 0.

Decomposition:
- Shared package reader_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One natural sub-module: reader_shift, the shift chain with an enable and a synchronous clear.
  - Controller drives its enable = (state==SHIFT) & si_valid & ~abort.
  - Clear = start accepted.

Test Plan:
- WIDTH=8; start, then 0xA5 MSB-first with si_valid every cycle -> dout_valid rises on the 8th bit edge, dout=8'hA5, bit_cnt=8; dout_ready=1 -> IDLE next cycle.
- Same frame with si_valid gapped (1,0,0,1,...) -> dout=8'hA5, no extra or missed bits.
- Hold dout_ready=0 for 5 cycles while strobing 2 extra bits -> dout stays 8'hA5, overrun=1; next start clears overrun.
- abort after 4 bits, then new frame 0x3C -> dout=8'h3C; no remnant of the first 4 bits.
- dout_ready and start in the same cycle, then 0xFF -> second word 8'hFF with no IDLE cycle between frames.
- READER_CTRL_PARITY_EN defined: 0x01 + parity 1 -> parity_err=0; 0x01 + parity 0 -> parity_err=1. Also: rst_n low mid-frame -> all outputs 0 asynchronously.
